// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: operand request / result bundle for serial_add_ctrl; sub exists only with SERIAL_ADD_SUBTRACT_EN
interface serial_add_ctrl_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
`ifdef SERIAL_ADD_SUBTRACT_EN
  logic             sub;
  modport master (output start, op_a, op_b, sub, input busy, done, result, carry_out);
  modport slave  (input start, op_a, op_b, sub, output busy, done, result, carry_out);
`else
  modport master (output start, op_a, op_b, input busy, done, result, carry_out);
  modport slave  (input start, op_a, op_b, output busy, done, result, carry_out);
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: LSB-first bit-serial adder over one external full adder; SERIAL_ADD_SUBTRACT_EN enables subtract
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_add_ctrl_if.slave  bus,
  output logic              fa_a,
  output logic              fa_b,
  output logic              fa_cin,
  input  logic              fa_sum,
  input  logic              fa_cout
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, result_q, result_d;
  logic             carry_q, carry_d, carry_out_q, carry_out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last, sub;
`ifdef SERIAL_ADD_SUBTRACT_EN
  assign sub = bus.sub;
`else
  assign sub = 1'b0;
`endif
  assign last = cnt_q == CW'(WIDTH - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      cnt_q       <= cnt_d;
    end
  always_comb begin
    state_d     = state_q == IDLE ? (bus.start ? ADD : IDLE) :
                  state_q == ADD  ? (last ? DONE : ADD) : IDLE;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    result_d    = result_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    cnt_d       = cnt_q;
    if (state_q == IDLE && bus.start) begin
      a_sh_d      = bus.op_a;
      b_sh_d      = sub ? ~bus.op_b : bus.op_b;
      result_d    = '0;
      carry_d     = sub;
      carry_out_d = 1'b0;
      cnt_d       = '0;
    end else if (state_q == ADD) begin
      a_sh_d      = a_sh_q >> 1;
      b_sh_d      = b_sh_q >> 1;
      result_d    = {fa_sum, result_q[WIDTH-1:1]};
      carry_d     = fa_cout;
      carry_out_d = last ? fa_cout : carry_out_q;
      cnt_d       = cnt_q + CW'(1);
    end
  end
  always_comb begin
    bus.busy      = state_q != IDLE;
    bus.done      = state_q == DONE;
    bus.result    = result_q;
    bus.carry_out = carry_out_q;
    fa_a          = state_q == ADD ? a_sh_q[0] : 1'b0;
    fa_b          = state_q == ADD ? b_sh_q[0] : 1'b0;
    fa_cin        = state_q == ADD ? carry_q : 1'b0;
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: vector table, corner sequences and randomized ops against an arithmetic reference
module tb_serial_add_ctrl;
  localparam int W = 8;
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] res;
    logic         cout;
  } vec_t;
  logic clk, rst_n, fa_a, fa_b, fa_cin, fa_sum, fa_cout;
  int checks, errors;
  vec_t vecs[$];
  serial_add_ctrl_if #(.WIDTH(W)) bus ();
  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_sum(fa_sum), .fa_cout(fa_cout)
  );
  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic vec_t mk(input logic [W-1:0] a, b, input logic s, input logic [W-1:0] res, input logic cout);
    vec_t v;
    v.a = a; v.b = b; v.s = s; v.res = res; v.cout = cout;
    return v;
  endfunction
  task automatic set_sub(input logic s);
`ifdef SERIAL_ADD_SUBTRACT_EN
    bus.sub = s;
`else
    if (s) check("sub_unsupported", 32'(s), 32'd0);
`endif
  endtask
  task automatic run_op(input logic [W-1:0] a, b, input logic s, input logic [W-1:0] er, input logic ec, input string tag);
    logic [W-1:0] fav, fbv, fcv, bb;
    logic [W:0]   full;
    logic         fa_idle;
    int n, nb;
    bb   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + (W+1)'(s);
    fav = '0; fbv = '0; fcv = '0; fa_idle = 1'b0; nb = 0;
    bus.op_a = a; bus.op_b = b; set_sub(s); bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (n = 1; n <= 40; n++) begin
      if (n > 1) tick();
      bus.op_a = W'($urandom);
      bus.op_b = W'($urandom);
      if (bus.busy) nb++;
      if (bus.done) begin
        fa_idle = fa_a | fa_b | fa_cin;
        break;
      end
      if (n <= W) begin
        fav[n-1] = fa_a;
        fbv[n-1] = fa_b;
        fcv[n-1] = fa_cin;
      end
    end
    check({tag, "_done_latency"}, 32'(n), 32'(W + 1));
    check({tag, "_busy_cycles"}, 32'(nb), 32'(W + 1));
    check({tag, "_result"}, 32'(bus.result), 32'(er));
    check({tag, "_carry_out"}, 32'(bus.carry_out), 32'(ec));
    check({tag, "_fa_a_seq"}, 32'(fav), 32'(a));
    check({tag, "_fa_b_seq"}, 32'(fbv), 32'(bb));
    check({tag, "_fa_cin_seq"}, 32'(fcv), 32'(full[W-1:0] ^ a ^ bb));
    check({tag, "_fa_idle_in_done"}, 32'(fa_idle), 32'd0);
    tick();
    check({tag, "_idle_after_done"}, {30'd0, bus.busy, bus.done}, 32'd0);
    tick();
    check({tag, "_result_held"}, {23'd0, bus.carry_out, bus.result}, {23'd0, ec, er});
  endtask
  initial begin
    int dn, pos[$];
    logic [W-1:0] ra, rb, er;
    logic rs, ec;
    checks = 0; errors = 0;
    rst_n = 1'b0; bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0; set_sub(1'b0);
    tick();
    tick();
    check("reset_outputs", {20'd0, bus.busy, bus.done, bus.carry_out, bus.result, fa_a, fa_b, fa_cin}, 32'd0);
    rst_n = 1'b1;
    tick();
    vecs.push_back(mk(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0));
    vecs.push_back(mk(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1));
    vecs.push_back(mk(8'h00, 8'h00, 1'b0, 8'h00, 1'b0));
    vecs.push_back(mk(8'h12, 8'h34, 1'b0, 8'h46, 1'b0));
    vecs.push_back(mk(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1));
    vecs.push_back(mk(8'h80, 8'h80, 1'b0, 8'h00, 1'b1));
    vecs.push_back(mk(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0));
`ifdef SERIAL_ADD_SUBTRACT_EN
    vecs.push_back(mk(8'h10, 8'h01, 1'b1, 8'h0F, 1'b1));
    vecs.push_back(mk(8'h00, 8'h01, 1'b1, 8'hFF, 1'b0));
    vecs.push_back(mk(8'h55, 8'h55, 1'b1, 8'h00, 1'b1));
    vecs.push_back(mk(8'h33, 8'h5A, 1'b0, 8'h8D, 1'b0));
`endif
    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].res, vecs[i].cout, "vec");
    bus.op_a = 8'h12; bus.op_b = 8'h34; set_sub(1'b0); bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    dn = 0;
    for (int k = 1; k <= 14; k++) begin
      if (k > 1) tick();
      dn += int'(bus.done);
      bus.start = k == 4;
      if (k == 4) bus.op_a = 8'hFF;
    end
    check("restart_done_count", 32'(dn), 32'd1);
    check("restart_result", {23'd0, bus.carry_out, bus.result}, 32'h046);
    bus.op_a = 8'h5A; bus.op_b = 8'h33; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {20'd0, bus.busy, bus.done, bus.carry_out, bus.result, fa_a, fa_b, fa_cin}, 32'd0);
    dn = 0;
    repeat (3) begin
      tick();
      dn += int'(bus.done);
    end
    rst_n = 1'b1;
    repeat (12) begin
      tick();
      dn += int'(bus.done);
    end
    check("abort_no_done", 32'(dn), 32'd0);
    run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "after_abort");
    bus.op_a = 8'h0F; bus.op_b = 8'h01; bus.start = 1'b1;
    dn = 0;
    for (int k = 0; k <= 30; k++) begin
      if (k > 0) tick();
      if (bus.done) begin
        pos.push_back(k);
        check("held_result", {23'd0, bus.carry_out, bus.result}, 32'h010);
      end
    end
    bus.start = 1'b0;
    check("held_done_count", 32'(pos.size()), 32'd3);
    if (pos.size() == 3) check("held_done_cycles", {8'(pos[0]), 8'(pos[1]), 8'(pos[2])}, {8'd9, 8'd19, 8'd29});
    repeat (12) tick();
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'b0;
`ifdef SERIAL_ADD_SUBTRACT_EN
      rs = 1'($urandom_range(0, 1));
`endif
      if (rs) begin
        er = ra - rb;
        ec = ra >= rb;
      end else begin
        {ec, er} = {1'b0, ra} + {1'b0, rb};
      end
      run_op(ra, rb, rs, er, ec, "rand");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial addition controller that time-shares one external single-bit full adder.
- Uses the existing sum/carry_in/carry_out cell.
- Captures two WIDTH-bit operands and feeds them LSB-first through the adder, one bit per clock.
- Accumulates the sum and final carry, then presents the result for the board top level to route to the hex display.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..16.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request an operation; level sampled only in IDLE.
- op_a  input  WIDTH  operand A; captured on the accepted start.
- op_b  input  WIDTH  operand B; captured on the accepted start.
- fa_a  output  1  bit of A to the full adder.
- fa_b  output  1  bit of B to the full adder.
- fa_cin  output  1  carry to the full adder.
- fa_sum  input  1  sum returned by the full adder (combinational, same cycle).
- fa_cout  input  1  carry returned by the full adder (combinational, same cycle).
- busy  output  1  high from the accepted start until done.
- done  output  1  one-cycle pulse when result and carry_out are valid.
- result  output  WIDTH  sum bits, held until the next accepted start.
- carry_out  output  1  final carry, held with result.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - busy, done, result, carry_out, fa_a, fa_b, fa_cin all 0.
  - Internal shift registers, carry register and bit counter all 0.
- States: IDLE, ADD, DONE.
- IDLE:
  - busy=0.
  - On a clk edge with start=1: op_a/op_b are captured into shift registers a_sh/b_sh, carry_reg=0, cnt=0, result cleared to 0; go to ADD.
- ADD:
  - busy=1.
  - Combinationally, fa_a=a_sh[0], fa_b=b_sh[0], fa_cin=carry_reg.
  - Each edge: result shifts right with fa_sum into the MSB; carry_reg<=fa_cout; a_sh/b_sh shift right; cnt++.
  - When cnt==WIDTH-1 at the edge, go to DONE. Exactly WIDTH ADD cycles occur.
- DONE:
  - busy=1, done=1 for this single cycle; carry_out=carry_reg (registered on ADD->DONE).
  - result now holds the full sum with LSB at bit 0.
  - Next edge unconditionally returns to IDLE.
- Latency: accepted start edge at cycle 0 -> ADD in cycles 1..WIDTH -> done high in cycle WIDTH+1 -> IDLE in WIDTH+2.
- fa_a, fa_b and fa_cin are 0 whenever state != ADD.
- start while busy is ignored; operands are not re-captured.
- start held continuously gives back-to-back operations, one done pulse every WIDTH+2 cycles.
- op_a/op_b changes after capture have no effect on the in-flight operation.
- result and carry_out remain stable in IDLE until the next accepted start. On that start, result and carry_out clear.
- Reset mid-operation aborts immediately to the reset values; no done pulse is produced.
- Arithmetic: {carry_out,result} = op_a + op_b modulo 2^(WIDTH+1).
- Counter width: $clog2(WIDTH); compare against WIDTH-1 without overflow.

Optional Feature:
- Macro: SERIAL_ADD_SUBTRACT_EN.
- When defined, an extra port sub (input, 1) is sampled with start.
  - If sub=1: b_sh captures ~op_b and carry_reg initialises to 1, so result = op_a - op_b mod 2^WIDTH.
  - carry_out=1 means no borrow (op_a >= op_b unsigned).
  - If sub=0: behaviour is identical to the base add.
- When not defined, the sub port does not exist and carry_reg always initialises to 0.

Test Plan:
- WIDTH=8, op_a=0x5A, op_b=0x33, start pulse -> busy for 9 cycles, done at cycle 9, result=0x8D, carry_out=0; fa_cin sequence observed LSB-first matches the ripple carries.
- op_a=0xFF, op_b=0x01 -> result=0x00, carry_out=1; op_a=0x00, op_b=0x00 -> result=0x00, carry_out=0, done still pulses.
- Accepted start 0x12+0x34, then start re-pulsed with op_a=0xFF at cycle 4 -> ignored; result=0x46, exactly one done pulse.
- rst_n low at cycle 5 of an operation -> all outputs 0 asynchronously, no done; after release with start 0x01+0x01 -> result=0x02.
- start held high for 30 cycles with constant operands 0x0F+0x01 -> done pulses at cycles 9, 19, 29; result=0x10 each time.
- With SERIAL_ADD_SUBTRACT_EN, sub=1: 0x10-0x01 -> result=0x0F, carry_out=1; 0x00-0x01 -> result=0xFF, carry_out=0.
